axi4_slave_mem: RTL and testbench

AXI4 memory-mapped responder backed by an internal register-array memory. It is the counterpart to the AXI4 master: it accepts write and read bursts, stores and returns data, and produces protocol-correct B and R responses. It is used as the far-end target in master testbenches and as a small on-chip scratch memory. It handles one transaction at a time, write or read, at a throughput of one data beat per clock.

---
 rtl/axi4_slave_mem.sv | 323 ++++++++++++++++++++++++++++++++
 tb/tb_axi4_slave_mem.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_slave_mem.sv
// -----------------------------------------------------------------------------
// axi4_slave_mem
//
// AXI4 memory-mapped responder backed by an internal byte-lane memory. It
// serves one transaction at a time (a write burst or a read burst) at one data
// beat per clock, and produces B / R responses with per-beat error
// classification (DECERR outside the memory, SLVERR for unsupported size or
// burst type, SLVERR for a wlast that disagrees with awlen).
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_aw*/o_awready              write address channel
//   i_w*/o_wready                write data channel
//   o_b*/i_bready                write response channel
//   i_ar*/o_arready              read address channel
//   o_r*/i_rready                read data channel
// -----------------------------------------------------------------------------
module axi4_slave_mem #(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int AXI_ID_WIDTH    = 4,
  parameter int MEM_DEPTH_WORDS = 256
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  // write address
  input  logic [AXI_ID_WIDTH-1:0]     i_awid,
  input  logic [AXI_ADDR_WIDTH-1:0]   i_awaddr,
  input  logic [7:0]                  i_awlen,
  input  logic [2:0]                  i_awsize,
  input  logic [1:0]                  i_awburst,
  input  logic                        i_awvalid,
  output logic                        o_awready,
  // write data
  input  logic [AXI_DATA_WIDTH-1:0]   i_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] i_wstrb,
  input  logic                        i_wlast,
  input  logic                        i_wvalid,
  output logic                        o_wready,
  // write response
  output logic [AXI_ID_WIDTH-1:0]     o_bid,
  output logic [1:0]                  o_bresp,
  output logic                        o_bvalid,
  input  logic                        i_bready,
  // read address
  input  logic [AXI_ID_WIDTH-1:0]     i_arid,
  input  logic [AXI_ADDR_WIDTH-1:0]   i_araddr,
  input  logic [7:0]                  i_arlen,
  input  logic [2:0]                  i_arsize,
  input  logic [1:0]                  i_arburst,
  input  logic                        i_arvalid,
  output logic                        o_arready,
  // read data
  output logic [AXI_ID_WIDTH-1:0]     o_rid,
  output logic [AXI_DATA_WIDTH-1:0]   o_rdata,
  output logic [1:0]                  o_rresp,
  output logic                        o_rlast,
  output logic                        o_rvalid,
  input  logic                        i_rready
);

  localparam int STRB_W   = AXI_DATA_WIDTH / 8;
  localparam int BYTE_LSB = $clog2(STRB_W);
  localparam int MEM_AW   = $clog2(MEM_DEPTH_WORDS);

  localparam logic [2:0]                FULL_SIZE = 3'(BYTE_LSB);
  localparam logic [AXI_ADDR_WIDTH-1:0] DEPTH_W   = AXI_ADDR_WIDTH'(MEM_DEPTH_WORDS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR_DATA,
    S_WR_RESP,
    S_RD_DATA
  } state_t;

  // Error class of a single beat. DECERR dominates: a beat outside the memory
  // is reported as such even when the burst is also malformed.
  function automatic logic [1:0] beat_resp(
    input logic [AXI_ADDR_WIDTH-1:0] addr,
    input logic [2:0]                size,
    input logic [1:0]                burst
  );
    logic [1:0] resp;
    resp = RESP_OKAY;
    if ((addr >> BYTE_LSB) >= DEPTH_W)
      resp = RESP_DECERR;
    else if ((size != FULL_SIZE) || burst[1])   // WRAP or reserved
      resp = RESP_SLVERR;
    return resp;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t                      r_state;
  logic                        r_prio_wr;     // 1: write wins the next conflict
  logic [AXI_ID_WIDTH-1:0]     r_id;
  logic [AXI_ADDR_WIDTH-1:0]   r_addr;
  logic [7:0]                  r_len;
  logic [7:0]                  r_cnt;
  logic [2:0]                  r_size;
  logic [1:0]                  r_burst;
  logic                        r_acc_dec;
  logic                        r_acc_slv;
  logic                        r_bvalid;
  logic [1:0]                  r_bresp;
  logic [AXI_ID_WIDTH-1:0]     r_bid;
  logic                        r_rvalid;
  logic [1:0]                  r_rresp;
  logic                        r_rlast;
  logic [AXI_ID_WIDTH-1:0]     r_rid;

  // ---------------------------------------------------------------------------
  // Arbitration and handshakes
  // ---------------------------------------------------------------------------
  logic w_idle;
  logic w_grant_wr;
  logic w_grant_rd;
  logic w_aw_hs;
  logic w_ar_hs;
  logic w_w_hs;

  assign w_idle     = (r_state == S_IDLE);
  assign w_grant_wr = i_awvalid && (r_prio_wr || !i_arvalid);
  assign w_grant_rd = i_arvalid && !w_grant_wr;

  // Ready is gated by reset so that no handshake can complete while the block
  // is being reset, whatever the valids are doing.
  assign o_awready = w_idle && w_grant_wr && !i_rst;
  assign o_arready = w_idle && w_grant_rd && !i_rst;
  assign o_wready  = (r_state == S_WR_DATA);

  assign w_aw_hs = i_awvalid && o_awready;
  assign w_ar_hs = i_arvalid && o_arready;
  assign w_w_hs  = i_wvalid && o_wready;

  // ---------------------------------------------------------------------------
  // Beat address sequencing (shared by write and read)
  // ---------------------------------------------------------------------------
  logic [AXI_ADDR_WIDTH-1:0] w_addr_step;
  logic [AXI_ADDR_WIDTH-1:0] w_addr_next;
  logic                      w_last_beat;

  assign w_addr_step = AXI_ADDR_WIDTH'(1) << r_size;
  assign w_addr_next = (r_burst == BURST_FIXED) ? r_addr : (r_addr + w_addr_step);
  assign w_last_beat = (r_cnt == r_len);

  // ---------------------------------------------------------------------------
  // Write beat evaluation
  // ---------------------------------------------------------------------------
  logic [1:0]        w_wr_resp;
  logic              w_wlast_err;
  logic              w_wr_en;
  logic [MEM_AW-1:0] w_wr_idx;
  logic              w_fin_dec;
  logic              w_fin_slv;
  logic [1:0]        w_fin_bresp;

  assign w_wr_resp   = beat_resp(r_addr, r_size, r_burst);
  assign w_wlast_err = (i_wlast != w_last_beat);
  assign w_wr_en     = w_w_hs && (w_wr_resp == RESP_OKAY) && !i_rst;
  assign w_wr_idx    = r_addr[BYTE_LSB +: MEM_AW];

  // Response including the beat being accepted right now.
  assign w_fin_dec   = r_acc_dec || (w_wr_resp == RESP_DECERR);
  assign w_fin_slv   = r_acc_slv || (w_wr_resp == RESP_SLVERR) || w_wlast_err;
  assign w_fin_bresp = w_fin_dec ? RESP_DECERR :
                       w_fin_slv ? RESP_SLVERR : RESP_OKAY;

  // ---------------------------------------------------------------------------
  // Read beat pre-fetch: the memory output register is loaded on the AR
  // handshake for beat 0 and on every non-final R handshake for the next beat,
  // so rdata is valid together with rvalid and holds while stalled.
  // ---------------------------------------------------------------------------
  logic              w_rd_adv;
  logic              w_rd_load;
  logic [1:0]        w_rd_resp;
  logic              w_rd_zero;
  logic [MEM_AW-1:0] w_rd_idx;

  assign w_rd_adv  = (r_state == S_RD_DATA) && i_rready && !r_rlast;
  assign w_rd_load = w_ar_hs || w_rd_adv;
  assign w_rd_resp = w_ar_hs ? beat_resp(i_araddr, i_arsize, i_arburst)
                             : beat_resp(w_addr_next, r_size, r_burst);
  assign w_rd_zero = (w_rd_resp != RESP_OKAY);
  assign w_rd_idx  = w_ar_hs ? i_araddr[BYTE_LSB +: MEM_AW]
                             : w_addr_next[BYTE_LSB +: MEM_AW];

  // ---------------------------------------------------------------------------
  // Memory: one byte-wide array per lane so strobes map to independent writes.
  // Contents are deliberately not reset.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < STRB_W; gi++) begin : g_lane
      logic [7:0] r_mem [MEM_DEPTH_WORDS];
      logic [7:0] r_rd_byte;

      always_ff @(posedge i_clk) begin
        if (w_wr_en && i_wstrb[gi])
          r_mem[w_wr_idx] <= i_wdata[gi*8 +: 8];
      end

      always_ff @(posedge i_clk) begin
        if (i_rst)
          r_rd_byte <= 8'h00;
        else if (w_rd_load)
          r_rd_byte <= w_rd_zero ? 8'h00 : r_mem[w_rd_idx];
      end

      assign o_rdata[gi*8 +: 8] = r_rd_byte;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Transaction FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_prio_wr <= 1'b1;
      r_id      <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_acc_dec <= 1'b0;
      r_acc_slv <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_bid     <= '0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rlast   <= 1'b0;
      r_rid     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_aw_hs) begin
            r_id      <= i_awid;
            r_addr    <= i_awaddr;
            r_len     <= i_awlen;
            r_size    <= i_awsize;
            r_burst   <= i_awburst;
            r_cnt     <= '0;
            r_acc_dec <= 1'b0;
            r_acc_slv <= 1'b0;
            r_prio_wr <= 1'b0;
            r_state   <= S_WR_DATA;
          end else if (w_ar_hs) begin
            r_id      <= i_arid;
            r_addr    <= i_araddr;
            r_len     <= i_arlen;
            r_size    <= i_arsize;
            r_burst   <= i_arburst;
            r_cnt     <= '0;
            r_rvalid  <= 1'b1;
            r_rid     <= i_arid;
            r_rresp   <= w_rd_resp;
            r_rlast   <= (i_arlen == 8'd0);
            r_prio_wr <= 1'b1;
            r_state   <= S_RD_DATA;
          end
        end

        S_WR_DATA: begin
          if (w_w_hs) begin
            r_cnt     <= r_cnt + 8'd1;
            r_addr    <= w_addr_next;
            r_acc_dec <= w_fin_dec;
            r_acc_slv <= w_fin_slv;
            // Burst length is governed by awlen alone; wlast only feeds bresp.
            if (w_last_beat) begin
              r_bvalid <= 1'b1;
              r_bid    <= r_id;
              r_bresp  <= w_fin_bresp;
              r_state  <= S_WR_RESP;
            end
          end
        end

        S_WR_RESP: begin
          if (i_bready) begin
            r_bvalid <= 1'b0;
            r_state  <= S_IDLE;
          end
        end

        S_RD_DATA: begin
          if (i_rready) begin
            if (r_rlast) begin
              r_rvalid <= 1'b0;
              r_rlast  <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              r_cnt   <= r_cnt + 8'd1;
              r_addr  <= w_addr_next;
              r_rresp <= w_rd_resp;
              r_rlast <= ((r_cnt + 8'd1) == r_len);
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_bvalid = r_bvalid;
  assign o_bresp  = r_bresp;
  assign o_bid    = r_bid;
  assign o_rvalid = r_rvalid;
  assign o_rresp  = r_rresp;
  assign o_rlast  = r_rlast;
  assign o_rid    = r_rid;

endmodule

// File: tb/tb_axi4_slave_mem.sv
// -----------------------------------------------------------------------------
// tb_axi4_slave_mem
//
// Directed bench for axi4_slave_mem: single write/read, INCR burst with read
// backpressure, byte strobes, DECERR / SLVERR cases, write/read arbitration
// and reset in the middle of a write burst. Expected values are written out
// by hand next to each step.
// -----------------------------------------------------------------------------
module tb_axi4_slave_mem;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [3:0]  i_awid;
  logic [31:0] i_awaddr;
  logic [7:0]  i_awlen;
  logic [2:0]  i_awsize;
  logic [1:0]  i_awburst;
  logic        i_awvalid;
  logic        o_awready;
  logic [31:0] i_wdata;
  logic [3:0]  i_wstrb;
  logic        i_wlast;
  logic        i_wvalid;
  logic        o_wready;
  logic [3:0]  o_bid;
  logic [1:0]  o_bresp;
  logic        o_bvalid;
  logic        i_bready;
  logic [3:0]  i_arid;
  logic [31:0] i_araddr;
  logic [7:0]  i_arlen;
  logic [2:0]  i_arsize;
  logic [1:0]  i_arburst;
  logic        i_arvalid;
  logic        o_arready;
  logic [3:0]  o_rid;
  logic [31:0] o_rdata;
  logic [1:0]  o_rresp;
  logic        o_rlast;
  logic        o_rvalid;
  logic        i_rready;

  int n_checks = 0;
  int n_errors = 0;

  axi4_slave_mem #(
    .AXI_ADDR_WIDTH (32),
    .AXI_DATA_WIDTH (32),
    .AXI_ID_WIDTH   (4),
    .MEM_DEPTH_WORDS(256)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_awid   (i_awid),
    .i_awaddr (i_awaddr),
    .i_awlen  (i_awlen),
    .i_awsize (i_awsize),
    .i_awburst(i_awburst),
    .i_awvalid(i_awvalid),
    .o_awready(o_awready),
    .i_wdata  (i_wdata),
    .i_wstrb  (i_wstrb),
    .i_wlast  (i_wlast),
    .i_wvalid (i_wvalid),
    .o_wready (o_wready),
    .o_bid    (o_bid),
    .o_bresp  (o_bresp),
    .o_bvalid (o_bvalid),
    .i_bready (i_bready),
    .i_arid   (i_arid),
    .i_araddr (i_araddr),
    .i_arlen  (i_arlen),
    .i_arsize (i_arsize),
    .i_arburst(i_arburst),
    .i_arvalid(i_arvalid),
    .o_arready(o_arready),
    .o_rid    (o_rid),
    .o_rdata  (o_rdata),
    .o_rresp  (o_rresp),
    .o_rlast  (o_rlast),
    .o_rvalid (o_rvalid),
    .i_rready (i_rready)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int   k;
    logic got;
    k = 0; got = 1'b0;
    i_awid = id; i_awaddr = addr; i_awlen = len; i_awsize = size; i_awburst = burst;
    i_awvalid = 1'b1;
    while (!got && k < 20) begin
      @(negedge i_clk);
      got = o_awready;
      step();
      k++;
    end
    i_awvalid = 1'b0;
    check("aw_accept", 64'(got), 64'd1);
    $display("txn AW id=%0d addr=0x%08h len=%0d size=%0d burst=%0d", id, addr, len, size, burst);
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int   k;
    logic got;
    k = 0; got = 1'b0;
    i_arid = id; i_araddr = addr; i_arlen = len; i_arsize = size; i_arburst = burst;
    i_arvalid = 1'b1;
    while (!got && k < 20) begin
      @(negedge i_clk);
      got = o_arready;
      step();
      k++;
    end
    i_arvalid = 1'b0;
    check("ar_accept", 64'(got), 64'd1);
    $display("txn AR id=%0d addr=0x%08h len=%0d size=%0d burst=%0d", id, addr, len, size, burst);
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last,
                        output int waited);
    int   k;
    logic got;
    k = 0; got = 1'b0;
    i_wdata = data; i_wstrb = strb; i_wlast = last; i_wvalid = 1'b1;
    while (!got && k < 20) begin
      @(negedge i_clk);
      got = o_wready;
      step();
      if (!got) k++;
    end
    i_wvalid = 1'b0;
    waited = k;
    check("w_accept", 64'(got), 64'd1);
    $display("txn W data=0x%08h strb=0x%0h last=%0d", data, strb, last);
  endtask

  task automatic recv_b(input string tag, input logic [3:0] id, input logic [1:0] resp,
                        output int waited);
    int   k;
    logic got;
    k = 0; got = 1'b0;
    i_bready = 1'b1;
    while (!got && k < 20) begin
      @(negedge i_clk);
      got = o_bvalid;
      if (got) check(tag, {o_bid, o_bresp}, {id, resp});
      step();
      if (!got) k++;
    end
    i_bready = 1'b0;
    waited = k;
    check({tag, "_seen"}, 64'(got), 64'd1);
    $display("txn B id=%0d resp=%0d", o_bid, o_bresp);
  endtask

  task automatic recv_r(input string tag, input logic [3:0] id, input logic [31:0] data,
                        input logic [1:0] resp, input logic last, output int waited);
    int   k;
    logic got;
    k = 0; got = 1'b0;
    i_rready = 1'b1;
    while (!got && k < 20) begin
      @(negedge i_clk);
      got = o_rvalid;
      if (got) check(tag, {o_rid, o_rdata, o_rresp, o_rlast}, {id, data, resp, last});
      step();
      if (!got) k++;
    end
    i_rready = 1'b0;
    waited = k;
    check({tag, "_seen"}, 64'(got), 64'd1);
    $display("txn R id=%0d data=0x%08h resp=%0d last=%0d", id, data, resp, last);
  endtask

  initial begin
    int  w;
    int  wmax;
    int  bcnt;
    logic exp_wr;

    i_rst = 1'b1;
    i_awid = '0; i_awaddr = '0; i_awlen = '0; i_awsize = '0; i_awburst = '0; i_awvalid = 1'b0;
    i_wdata = '0; i_wstrb = '0; i_wlast = 1'b0; i_wvalid = 1'b0; i_bready = 1'b0;
    i_arid = '0; i_araddr = '0; i_arlen = '0; i_arsize = '0; i_arburst = '0; i_arvalid = 1'b0;
    i_rready = 1'b0;

    // ---- reset state ----
    step(); step(); step();
    @(negedge i_clk);
    check("reset_outputs",
          {o_awready, o_wready, o_bvalid, o_bresp, o_bid, o_arready,
           o_rvalid, o_rresp, o_rlast, o_rid, o_rdata}, 64'd0);
    step();
    i_rst = 1'b0;
    step();

    // ---- single write then read ----
    send_aw(4'd3, 32'h10, 8'd0, 3'd2, 2'b01);
    send_w(32'hDEADBEEF, 4'hF, 1'b1, w);
    check("single_wready_latency", 64'(w), 64'd0);
    recv_b("single_b", 4'd3, 2'b00, w);
    check("single_bvalid_latency", 64'(w), 64'd0);
    send_ar(4'd5, 32'h10, 8'd0, 3'd2, 2'b01);
    recv_r("single_r", 4'd5, 32'hDEADBEEF, 2'b00, 1'b1, w);
    check("single_rvalid_latency", 64'(w), 64'd0);

    // ---- INCR burst len 7 at 0x40, data i+1 ----
    send_aw(4'd1, 32'h40, 8'd7, 3'd2, 2'b01);
    wmax = 0;
    for (int i = 0; i < 8; i++) begin
      send_w(32'(i + 1), 4'hF, (i == 7), w);
      if (w > wmax) wmax = w;
    end
    check("burst_w_back_to_back", 64'(wmax), 64'd0);
    recv_b("burst_b", 4'd1, 2'b00, w);

    // read back with rready toggling 0/1: stall cycle then accept cycle
    send_ar(4'd2, 32'h40, 8'd7, 3'd2, 2'b01);
    for (int b = 0; b < 8; b++) begin
      i_rready = 1'b0;
      @(negedge i_clk);
      check("burst_r_stall", {o_rvalid, o_rid, o_rdata, o_rresp, o_rlast},
            {1'b1, 4'd2, 32'(b + 1), 2'b00, (b == 7)});
      step();
      i_rready = 1'b1;
      @(negedge i_clk);
      check("burst_r_beat", {o_rvalid, o_rid, o_rdata, o_rresp, o_rlast},
            {1'b1, 4'd2, 32'(b + 1), 2'b00, (b == 7)});
      step();
      $display("txn R beat=%0d data=0x%08h", b, b + 1);
    end
    i_rready = 1'b0;
    @(negedge i_clk);
    check("burst_r_done", 64'(o_rvalid), 64'd0);
    step();

    // ---- strobes ----
    send_aw(4'd4, 32'h0, 8'd0, 3'd2, 2'b01);
    send_w(32'h11223344, 4'hF, 1'b1, w);
    recv_b("strb_b0", 4'd4, 2'b00, w);
    send_aw(4'd4, 32'h0, 8'd0, 3'd2, 2'b01);
    send_w(32'hAABBCCDD, 4'h5, 1'b1, w);
    recv_b("strb_b1", 4'd4, 2'b00, w);
    send_ar(4'd4, 32'h0, 8'd0, 3'd2, 2'b01);
    recv_r("strb_r", 4'd4, 32'h11BB33DD, 2'b00, 1'b1, w);

    // ---- DECERR: len 1 starting at the last word (0x3FC); beat 2 is 0x400 ----
    send_aw(4'd9, 32'h3FC, 8'd1, 3'd2, 2'b01);
    send_w(32'hCAFEF00D, 4'hF, 1'b0, w);
    send_w(32'h55555555, 4'hF, 1'b1, w);
    recv_b("decerr_b", 4'd9, 2'b11, w);
    send_ar(4'd9, 32'h3FC, 8'd0, 3'd2, 2'b01);
    recv_r("decerr_last_word", 4'd9, 32'hCAFEF00D, 2'b00, 1'b1, w);
    // index 256 would alias word 0 if the write had not been suppressed
    send_ar(4'd9, 32'h0, 8'd0, 3'd2, 2'b01);
    recv_r("decerr_no_alias", 4'd9, 32'h11BB33DD, 2'b00, 1'b1, w);
    send_ar(4'd9, 32'h400, 8'd0, 3'd2, 2'b01);
    recv_r("decerr_read", 4'd9, 32'h0, 2'b11, 1'b1, w);

    // ---- WRAP read: every beat SLVERR with zero data ----
    send_ar(4'd10, 32'h40, 8'd3, 3'd2, 2'b10);
    for (int b = 0; b < 4; b++)
      recv_r("wrap_r", 4'd10, 32'h0, 2'b10, (b == 3), w);

    // ---- unsupported size: SLVERR ----
    send_ar(4'd7, 32'h10, 8'd0, 3'd1, 2'b01);
    recv_r("size_r", 4'd7, 32'h0, 2'b10, 1'b1, w);

    // ---- early wlast on beat 1 of len 3 ----
    send_aw(4'd11, 32'h80, 8'd3, 3'd2, 2'b01);
    bcnt = 0;
    for (int i = 0; i < 4; i++) begin
      send_w(32'hA0 + 32'(i), 4'hF, (i == 0) || (i == 3), w);
      if (w == 0) bcnt++;
    end
    check("wlast_beats_accepted", 64'(bcnt), 64'd4);
    recv_b("wlast_b", 4'd11, 2'b10, w);
    check("wlast_b_latency", 64'(w), 64'd0);

    // ---- arbitration after a fresh reset: write, read, write ----
    i_rst = 1'b1;
    step(); step();
    i_rst = 1'b0;
    step();
    for (int r = 0; r < 3; r++) begin
      exp_wr = (r != 1);
      i_awid = 4'(r); i_awaddr = 32'hC0 + 32'(4 * r); i_awlen = 8'd0; i_awsize = 3'd2; i_awburst = 2'b01;
      i_arid = 4'(8 + r); i_araddr = 32'h10; i_arlen = 8'd0; i_arsize = 3'd2; i_arburst = 2'b01;
      i_awvalid = 1'b1;
      i_arvalid = 1'b1;
      @(negedge i_clk);
      check("arb_grant", {o_awready, o_arready}, exp_wr ? 64'b10 : 64'b01);
      step();
      if (exp_wr) begin
        i_awvalid = 1'b0;
        send_w(32'hB0 + 32'(r), 4'hF, 1'b1, w);
        @(negedge i_clk);
        check("arb_no_overlap_wr", {o_bvalid, o_arready}, 64'b10);
        step();
        recv_b("arb_b", 4'(r), 2'b00, w);
        i_arvalid = 1'b0;
      end else begin
        i_arvalid = 1'b0;
        @(negedge i_clk);
        check("arb_no_overlap_rd", {o_rvalid, o_awready}, 64'b10);
        step();
        recv_r("arb_r", 4'(8 + r), 32'hDEADBEEF, 2'b00, 1'b1, w);
        i_awvalid = 1'b0;
      end
      $display("txn ARB round=%0d granted=%s", r, exp_wr ? "write" : "read");
    end

    // ---- reset in the middle of a write burst ----
    send_aw(4'd6, 32'h100, 8'd7, 3'd2, 2'b01);
    send_w(32'h70, 4'hF, 1'b0, w);
    send_w(32'h71, 4'hF, 1'b0, w);
    i_rst = 1'b1;
    step();
    @(negedge i_clk);
    check("midreset_outputs",
          {o_awready, o_wready, o_bvalid, o_bresp, o_bid, o_arready,
           o_rvalid, o_rresp, o_rlast, o_rid, o_rdata}, 64'd0);
    step();
    i_rst = 1'b0;
    bcnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      if (o_bvalid) bcnt++;
      step();
    end
    check("midreset_no_b", 64'(bcnt), 64'd0);
    send_aw(4'd12, 32'h200, 8'd0, 3'd2, 2'b01);
    send_w(32'h12345678, 4'hF, 1'b1, w);
    recv_b("midreset_new_b", 4'd12, 2'b00, w);
    send_ar(4'd13, 32'h100, 8'd1, 3'd2, 2'b01);
    recv_r("midreset_beat0", 4'd13, 32'h70, 2'b00, 1'b0, w);
    recv_r("midreset_beat1", 4'd13, 32'h71, 2'b00, 1'b1, w);

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
